btb_update_queue: RTL and testbench

//  Write-side feeder for the branch target buffer. Takes resolved branches from
//  the branch/commit unit, buffers the taken ones in a FIFO, and drains one

---
 rtl/btb_update_queue_if.sv | 27 ++
 rtl/btb_update_queue.sv | 103 ++++++++++
 tb/tb_btb_update_queue.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_queue_if.sv
// Bus bundle between the branch/commit unit, fetch snoop and the BTB write port.
// The master side drives resolved branches and the snooped read; the slave side is the queue.
interface btb_update_queue_if;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_target;
  logic        flush;
  logic        btb_rd;
  logic [31:0] btb_raddr;
  logic        btb_wr;
  logic [31:0] btb_waddr;
  logic [31:0] btb_din;
  logic        q_full;
  logic        q_empty;
  logic [15:0] drop_cnt;

  modport master (
    output br_valid, br_taken, br_pc, br_target, flush, btb_rd, btb_raddr,
    input  btb_wr, btb_waddr, btb_din, q_full, q_empty, drop_cnt
  );

  modport slave (
    input  br_valid, br_taken, br_pc, br_target, flush, btb_rd, btb_raddr,
    output btb_wr, btb_waddr, btb_din, q_full, q_empty, drop_cnt
  );
endinterface

// File: rtl/btb_update_queue.sv
// Queues taken branches and drains one per cycle into the BTB write port,
// deferring writes that hit the set fetch is reading, with a bounded stall.
module btb_update_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STALL_MAX = 3,
  parameter int unsigned SET_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  btb_update_queue_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = $clog2(STALL_MAX + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic          empty, full;
  logic          req, coalesce, accept, drop;
  logic          collision, deq;
  logic [AW-1:0] newest_idx;
  entry_t        head, newest;
  logic          unused_raddr_bits;

  // Queue status, head/newest lookup and the write/enqueue decisions
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    head       = mem_q[rd_ptr_q[AW-1:0]];
    newest_idx = wr_ptr_q[AW-1:0] - AW'(1);
    newest     = mem_q[newest_idx];

    collision  = bus.btb_rd && (bus.btb_raddr[2 +: SET_W] == head.pc[2 +: SET_W]);
    deq        = !empty && (!collision || (stall_cnt_q == SW'(STALL_MAX)));

    req        = bus.br_valid && bus.br_taken && !bus.flush;
    coalesce   = req && !empty && (newest.pc == bus.br_pc) && (newest.tgt == bus.br_target);
    accept     = req && !coalesce && (!full || deq);
    drop       = req && !coalesce && full && !deq;
  end

  // Next-state for pointers and counters; flush overrides everything but drop_cnt
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq)    rd_ptr_d = rd_ptr_q + PW'(1);

    // Non-empty without a write can only mean a deferred collision
    if (deq || empty) stall_cnt_d = '0;
    else              stall_cnt_d = stall_cnt_q + SW'(1);

    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;

    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Entry storage needs no reset: contents are only visible while non-empty
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= '{pc: bus.br_pc, tgt: bus.br_target};
  end

  assign bus.btb_wr    = deq;
  assign bus.btb_waddr = empty ? 32'd0 : head.pc;
  assign bus.btb_din   = empty ? 32'd0 : head.tgt;
  assign bus.q_full    = full;
  assign bus.q_empty   = empty;
  assign bus.drop_cnt  = drop_cnt_q;

  assign unused_raddr_bits = ^{bus.btb_raddr[31:2+SET_W], bus.btb_raddr[1:0]};

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: inputs change on the falling edge,
// outputs are checked 1 time unit later, state advances on the rising edge.
module tb_btb_update_queue;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  btb_update_queue_if bus ();

  btb_update_queue #(.DEPTH(4), .STALL_MAX(3), .SET_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic t, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic fl, input logic rd, input logic [31:0] ra);
    bus.br_valid  = v;
    bus.br_taken  = t;
    bus.br_pc     = pc;
    bus.br_target = tgt;
    bus.flush     = fl;
    bus.btb_rd    = rd;
    bus.btb_raddr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    #1;
    chk("rst_wr",    32'(bus.btb_wr),    32'd0);
    chk("rst_empty", 32'(bus.q_empty),   32'd1);
    chk("rst_full",  32'(bus.q_full),    32'd0);
    chk("rst_drop",  32'(bus.drop_cnt),  32'd0);
    chk("rst_waddr", bus.btb_waddr,      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single taken branch: visible the cycle after acceptance, for one cycle
    drive(1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 32'd0);
    #1;
    chk("single_nobypass", 32'(bus.btb_wr), 32'd0);
    step();
    idle();
    #1;
    chk("single_wr",    32'(bus.btb_wr), 32'd1);
    chk("single_waddr", bus.btb_waddr,   32'h100);
    chk("single_din",   bus.btb_din,     32'h200);
    step();
    #1;
    chk("single_done_wr",    32'(bus.btb_wr),  32'd0);
    chk("single_done_empty", 32'(bus.q_empty), 32'd1);

    // Collision stall: same set held 3 cycles, forced on the 4th
    drive(1'b1, 1'b1, 32'h104, 32'h300, 1'b0, 1'b0, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h204);
    #1;
    chk("stall_c0", 32'(bus.btb_wr), 32'd0);
    step();
    #1;
    chk("stall_c1", 32'(bus.btb_wr), 32'd0);
    step();
    #1;
    chk("stall_c2", 32'(bus.btb_wr), 32'd0);
    step();
    #1;
    chk("stall_forced",       32'(bus.btb_wr), 32'd1);
    chk("stall_forced_waddr", bus.btb_waddr,   32'h104);
    step();
    #1;
    chk("stall_after_empty", 32'(bus.q_empty), 32'd1);
    drive(1'b1, 1'b1, 32'h104, 32'h304, 1'b0, 1'b1, 32'h208);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h208);
    #1;
    chk("nostall_wr",  32'(bus.btb_wr), 32'd1);
    chk("nostall_din", bus.btb_din,     32'h304);
    step();

    // Coalesce of an identical back-to-back pair; not-taken never enqueues
    drive(1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 32'd0);
    step();
    #1;
    chk("coal_wr",    32'(bus.btb_wr), 32'd1);
    chk("coal_waddr", bus.btb_waddr,   32'h40);
    step();
    idle();
    #1;
    chk("coal_empty", 32'(bus.q_empty),  32'd1);
    chk("coal_wr2",   32'(bus.btb_wr),   32'd0);
    chk("coal_drop",  32'(bus.drop_cnt), 32'd0);
    drive(1'b1, 1'b0, 32'h44, 32'h88, 1'b0, 1'b0, 32'd0);
    step();
    idle();
    #1;
    chk("nt_wr",    32'(bus.btb_wr),  32'd0);
    chk("nt_empty", 32'(bus.q_empty), 32'd1);

    // Fill under collision: forced drain at cycle 4 makes room, cycles 5/6 drop
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 32'h1000 + 32'(i) * 32'h40, 32'h8000 + 32'(i), 1'b0, 1'b1, 32'h2000);
      #1;
      if (i == 4) begin
        chk("fill_c4_full",  32'(bus.q_full),   32'd1);
        chk("fill_c4_wr",    32'(bus.btb_wr),   32'd1);
        chk("fill_c4_waddr", bus.btb_waddr,     32'h1000);
      end
      if (i == 5) begin
        chk("fullenq_full", 32'(bus.q_full),   32'd1);
        chk("fullenq_drop", 32'(bus.drop_cnt), 32'd0);
        chk("fill_c5_wr",   32'(bus.btb_wr),   32'd0);
      end
      if (i == 6) chk("fill_c6_drop", 32'(bus.drop_cnt), 32'd1);
      step();
    end
    idle();
    for (int j = 1; j <= 4; j++) begin
      #1;
      if (j == 1) begin
        chk("fill_drop", 32'(bus.drop_cnt), 32'd2);
        chk("fill_full", 32'(bus.q_full),   32'd1);
      end
      chk("drain_wr",    32'(bus.btb_wr), 32'd1);
      chk("drain_waddr", bus.btb_waddr,   32'h1000 + 32'(j) * 32'h40);
      chk("drain_din",   bus.btb_din,     32'h8000 + 32'(j));
      step();
    end
    #1;
    chk("drain_empty", 32'(bus.q_empty), 32'd1);

    // Flush with three queued entries; same-cycle branch is ignored
    drive(1'b1, 1'b1, 32'h3000, 32'h10, 1'b0, 1'b1, 32'h5000);
    step();
    drive(1'b1, 1'b1, 32'h3040, 32'h11, 1'b0, 1'b1, 32'h5000);
    step();
    drive(1'b1, 1'b1, 32'h3080, 32'h12, 1'b0, 1'b1, 32'h5000);
    step();
    drive(1'b1, 1'b1, 32'h30C0, 32'h13, 1'b1, 1'b1, 32'h5000);
    #1;
    chk("flush_pre_wr",    32'(bus.btb_wr),  32'd0);
    chk("flush_pre_empty", 32'(bus.q_empty), 32'd0);
    step();
    idle();
    #1;
    chk("flush_empty", 32'(bus.q_empty),  32'd1);
    chk("flush_wr",    32'(bus.btb_wr),   32'd0);
    chk("flush_drop",  32'(bus.drop_cnt), 32'd2);
    drive(1'b1, 1'b1, 32'h3100, 32'h14, 1'b0, 1'b0, 32'd0);
    step();
    idle();
    #1;
    chk("postflush_wr",    32'(bus.btb_wr), 32'd1);
    chk("postflush_waddr", bus.btb_waddr,   32'h3100);
    step();

    // Asynchronous reset in the middle of a drain cycle
    drive(1'b1, 1'b1, 32'h500, 32'h600, 1'b0, 1'b0, 32'd0);
    step();
    idle();
    #1;
    chk("arst_pre_wr", 32'(bus.btb_wr), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr",    32'(bus.btb_wr),   32'd0);
    chk("arst_empty", 32'(bus.q_empty),  32'd1);
    chk("arst_drop",  32'(bus.drop_cnt), 32'd0);
    chk("arst_waddr", bus.btb_waddr,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_release_empty", 32'(bus.q_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
